// File: rtl/isa_defs_pkg.sv
// Shared ISA constants for the 16-bit pipeline: NOP encoding, HALT opcode,
// opcode field position, and the IF/ID entry layout.
package isa_defs_pkg;

    localparam logic [15:0] NOP_ENC     = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
    localparam int          OPC_MSB     = 15;
    localparam int          OPC_LSB     = 11;

    // One fetched instruction together with its PC and PC+2.
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_next;
    } ifid_entry_t;

    // True when the opcode field of instr matches the given HALT opcode.
    function automatic logic is_halt(input logic [15:0] instr, input logic [4:0] halt_opc);
        return instr[OPC_MSB:OPC_LSB] == halt_opc;
    endfunction

endpackage

// File: rtl/ifid_ptr_ctrl.sv
// Pointer/occupancy control for the IF/ID buffer: read/write pointers,
// entry count and HALT fence, with reset > flush > normal push/pop priority.
// Handshake: a push happens on an edge where if_valid_i & if_ready_o & !flush_i;
// a pop happens where id_valid_o & id_ready_i & !flush_i. if_ready_o is a
// function of registered state and rst only, never of id_ready_i.
module ifid_ptr_ctrl
    import isa_defs_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             if_valid_i,
    input  logic             id_ready_i,
    input  logic             push_halt_i,
    output logic             if_ready_o,
    output logic             id_valid_o,
    output logic             push_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic             halt_seen_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             halt_q, halt_d;
    logic             pop;

    assign if_ready_o  = !rst && (count_q < CNT_W'(DEPTH)) && !halt_q;
    assign id_valid_o  = (count_q != '0);
    assign push_o      = if_valid_i && if_ready_o && !flush_i;
    assign pop         = id_valid_o && id_ready_i && !flush_i;
    assign wr_ptr_o    = wr_ptr_q;
    assign rd_ptr_o    = rd_ptr_q;
    assign halt_seen_o = halt_q;

    // Next-state for pointers, count and HALT fence; flush wipes everything.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        halt_d   = halt_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            halt_d   = 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_o) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (push_halt_i) halt_d = 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_o, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            halt_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            halt_q   <= halt_d;
        end
    end

endmodule

// File: rtl/if_id_buffer.sv
// Elastic IF/ID boundary: DEPTH-entry queue of {instr, PC, PC+2} between
// fetch and decode, with flush, HALT fencing and NOP injection when empty.
module if_id_buffer
    import isa_defs_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = NOP_ENC,
    parameter logic [4:0]  HALT_OPC  = HALT_OPCODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc,
    input  logic [15:0] if_pc_next,
    output logic        if_ready,
    output logic        id_valid,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_next,
    input  logic        id_ready,
    input  logic        flush,
    output logic        halt_seen
);

    localparam int PTR_W = $clog2(DEPTH);

    ifid_entry_t      mem_q [DEPTH];
    ifid_entry_t      head;
    logic             push;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    ifid_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .if_valid_i  (if_valid),
        .id_ready_i  (id_ready),
        .push_halt_i (is_halt(if_instr, HALT_OPC)),
        .if_ready_o  (if_ready),
        .id_valid_o  (id_valid),
        .push_o      (push),
        .wr_ptr_o    (wr_ptr),
        .rd_ptr_o    (rd_ptr),
        .halt_seen_o (halt_seen)
    );

    // Entry storage; no reset needed because outputs are masked by id_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= '{instr: if_instr, pc: if_pc, pc_next: if_pc_next};
        end
    end

    // Head mux: present the oldest entry, or a NOP bubble when empty.
    always_comb begin
        head = mem_q[rd_ptr];
        if (id_valid) begin
            id_instr   = head.instr;
            id_pc      = head.pc;
            id_pc_next = head.pc_next;
        end else begin
            id_instr   = NOP_INSTR;
            id_pc      = 16'h0000;
            id_pc_next = 16'h0000;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_if_id_buffer;

    localparam int DEPTH = 2;
    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_next;
    logic        if_ready;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_next;
    logic        id_ready;
    logic        flush;
    logic        halt_seen;

    // reference model state
    logic [47:0] exp_q[$];
    logic        exp_halt;

    int n_vec = 0;
    int n_err = 0;

    if_id_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pc_next (if_pc_next),
        .if_ready   (if_ready),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_pc_next (id_pc_next),
        .id_ready   (id_ready),
        .flush      (flush),
        .halt_seen  (halt_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return !rst && (exp_q.size() < DEPTH) && !exp_halt;
    endfunction

    // Compare all observable outputs against the model (called at negedge).
    task automatic compare_all();
        logic [47:0] h;
        check("if_ready", {15'd0, if_ready}, {15'd0, model_ready()});
        check("halt_seen", {15'd0, halt_seen}, {15'd0, exp_halt});
        check("id_valid", {15'd0, id_valid}, {15'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check("id_instr", id_instr, h[47:32]);
            check("id_pc", id_pc, h[31:16]);
            check("id_pc_next", id_pc_next, h[15:0]);
        end else begin
            check("id_instr", id_instr, NOP);
            check("id_pc", id_pc, 16'h0000);
            check("id_pc_next", id_pc_next, 16'h0000);
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, then compare.
    task automatic step(input logic v, input logic [15:0] instr, input logic [15:0] pc,
                        input logic idr, input logic fl, input logic r);
        logic do_push, do_pop;
        rst = r; if_valid = v; if_instr = instr; if_pc = pc; if_pc_next = pc + 16'd2;
        id_ready = idr; flush = fl;
        do_push = v && model_ready() && !fl;
        do_pop  = (exp_q.size() != 0) && idr && !fl;
        @(posedge clk);
        if (r || fl) begin
            exp_q.delete();
            exp_halt = 1'b0;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back({instr, pc, pc + 16'd2});
                if (instr[15:11] == 5'b00000) exp_halt = 1'b1;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [15:0] op(input logic [15:0] pc);
        return 16'h8000 | pc;
    endfunction

    initial begin
        exp_halt = 1'b0;
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; if_pc_next = '0;
        id_ready = 1'b0; flush = 1'b0;

        // 1 reset
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("rst_nop", id_instr, 16'h0800);
        check("rst_ready", {15'd0, if_ready}, 16'd0);
        step(0, 0, 0, 0, 0, 0);
        check("post_rst_ready", {15'd0, if_ready}, 16'd1);

        // 2 streaming
        step(1, op(0), 0, 1, 0, 0);
        check("stream_pc0", id_pc, 16'd0);
        step(1, op(2), 2, 1, 0, 0);
        check("stream_pc2", id_pc, 16'd2);
        step(1, op(4), 4, 1, 0, 0);
        check("stream_pc4", id_pc, 16'd4);
        step(0, 0, 0, 1, 0, 0);

        // 3 stall / full
        step(1, op(0), 0, 0, 0, 0);
        step(1, op(2), 2, 0, 0, 0);
        check("full_ready", {15'd0, if_ready}, 16'd0);
        step(1, op(4), 4, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("drain_pc2", id_pc, 16'd2);
        step(0, 0, 0, 1, 0, 0);
        check("drain_empty", {15'd0, id_valid}, 16'd0);

        // 4 flush with simultaneous push and pop
        step(1, op(8), 8, 0, 0, 0);
        step(1, op(10), 10, 0, 0, 0);
        step(1, op(12), 12, 1, 1, 0);
        check("flush_nop", id_instr, 16'h0800);
        step(0, 0, 0, 1, 0, 0);

        // 5 HALT
        step(1, 16'h0000, 6, 0, 0, 0);
        check("halt_seen", {15'd0, halt_seen}, 16'd1);
        step(1, op(8), 8, 0, 0, 0);
        check("halt_pc", id_pc, 16'd6);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("halt_clear", {15'd0, halt_seen}, 16'd0);

        // 6 reset mid-stream
        step(1, op(20), 20, 0, 0, 0);
        step(1, op(22), 22, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] instr;
            instr = 16'($urandom);
            if ($urandom_range(0, 15) == 0) instr[15:11] = 5'b00000;
            step($urandom_range(0, 9) < 7, instr, 16'($urandom) & 16'hfffe,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
